// File: rtl/cam_pix_capture_pkg.sv
// Shared types for the OV7670 pixel capture path: pixel formats, FSM states,
// error flag positions and the byte-pair to pixel packer.
package cam_pkg;

  typedef enum logic [1:0] {
    MODE_RGB444 = 2'b00,
    MODE_RGB565 = 2'b01,
    MODE_GRAY   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  localparam int ERR_OVF = 2;
  localparam int ERR_LEN = 1;
  localparam int ERR_CNT = 0;

  // Output is always 4:4:4 as R[11:8] G[7:4] B[3:0]; b0 is the first byte of the pair.
  function automatic logic [11:0] pix_pack(mode_e mode, logic [7:0] b0, logic [7:0] b1);
    case (mode)
      MODE_RGB444: pix_pack = {b0[3:0], b1};
      MODE_RGB565: pix_pack = {b0[7:4], b0[2:0], b1[7], b1[4:1]};
      MODE_GRAY:   pix_pack = {3{b0[7:4]}};
      default:     pix_pack = '0;
    endcase
  endfunction

endpackage

// File: rtl/cam_pix_capture_if.sv
// Camera-side inputs and BRAM write-side outputs of the capture block.
interface cam_pix_capture_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 12,
  parameter int FCNT_W = 8
);
  import cam_pkg::*;

  logic              i_en;
  mode_e             i_mode;
  logic              i_vsync;
  logic              i_href;
  logic [7:0]        i_byte;
  logic              o_pix_wr;
  logic [ADDR_W-1:0] o_pix_addr;
  logic [PIX_W-1:0]  o_pix_data;
  logic              o_frame_done;
  logic [FCNT_W-1:0] o_frame_cnt;
  logic [2:0]        o_err;

  modport master (
    output i_en, i_mode, i_vsync, i_href, i_byte,
    input  o_pix_wr, o_pix_addr, o_pix_data, o_frame_done, o_frame_cnt, o_err
  );

  modport slave (
    input  i_en, i_mode, i_vsync, i_href, i_byte,
    output o_pix_wr, o_pix_addr, o_pix_data, o_frame_done, o_frame_cnt, o_err
  );
endinterface

// File: rtl/cam_pix_capture_sync_edge.sv
// One-stage registers on VSYNC/HREF with the edges the capture FSM consumes.
module cam_sync_edge (
  input  logic i_pclk,
  input  logic i_rstn_pclk,
  input  logic i_vsync,
  input  logic i_href,
  output logic vs_rise,
  output logic vs_fall,
  output logic href_q,
  output logic href_fall
);
  logic vs_q;

  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) begin
      vs_q   <= 1'b0;
      href_q <= 1'b0;
    end else begin
      vs_q   <= i_vsync;
      href_q <= i_href;
    end
  end

  assign vs_rise   =  i_vsync & ~vs_q;
  assign vs_fall   = ~i_vsync &  vs_q;
  assign href_fall = ~i_href  &  href_q;
endmodule

// File: rtl/cam_pix_capture.sv
// OV7670 byte stream to linear BRAM pixel writes, with format select,
// power-of-two decimation, frame/line size checking and a frame counter.
module cam_pix_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int PIX_W      = 12,
  parameter int DECIM_LOG2 = 0,
  parameter int ADDR_W     = 19,
  parameter int FCNT_W     = 8
) (
  input  logic             i_pclk,
  input  logic             i_rstn_pclk,
  cam_pix_capture_if.slave bus
);
  localparam int              PIX_MAX   = (H_ACTIVE >> DECIM_LOG2) * (V_ACTIVE >> DECIM_LOG2);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIX_MAX - 1);
  localparam logic [15:0]     DMASK     = 16'((1 << DECIM_LOG2) - 1);
  localparam logic [15:0]     H_END     = 16'(H_ACTIVE);
  localparam logic [15:0]     V_END     = 16'(V_ACTIVE);

  state_e            state;
  mode_e             mode_q;
  logic [15:0]       x, y, y_end;
  logic [ADDR_W-1:0] addr;
  logic              full, phase;
  logic [7:0]        b0;
  logic              vs_rise, vs_fall, href_q, href_fall;
  logic              byte_ok, pix_done, keep, line_end;

  cam_sync_edge u_sync (
    .i_pclk      (i_pclk),
    .i_rstn_pclk (i_rstn_pclk),
    .i_vsync     (bus.i_vsync),
    .i_href      (bus.i_href),
    .vs_rise     (vs_rise),
    .vs_fall     (vs_fall),
    .href_q      (href_q),
    .href_fall   (href_fall)
  );

  // Bytes arriving on the vsync-rise cycle belong to no frame and are dropped.
  assign byte_ok  = (state == S_ACTIVE) & bus.i_href & ~vs_rise;
  assign pix_done = byte_ok & phase;
  assign keep     = ((x & DMASK) == 16'd0) && ((y & DMASK) == 16'd0) && (mode_q != MODE_RSVD);
  // A line still open when vsync rises is closed by that rise.
  assign line_end = href_fall | (vs_rise & href_q);
  assign y_end    = y + {15'd0, line_end};

  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) begin
      state            <= S_IDLE;
      mode_q           <= MODE_RGB444;
      x                <= '0;
      y                <= '0;
      addr             <= '0;
      full             <= 1'b0;
      phase            <= 1'b0;
      b0               <= '0;
      bus.o_pix_wr     <= 1'b0;
      bus.o_pix_addr   <= '0;
      bus.o_pix_data   <= '0;
      bus.o_frame_done <= 1'b0;
      bus.o_frame_cnt  <= '0;
      bus.o_err        <= '0;
    end else begin
      bus.o_pix_wr     <= 1'b0;
      bus.o_frame_done <= 1'b0;
      phase            <= byte_ok & ~phase;
      if (byte_ok && !phase) b0 <= bus.i_byte;

      case (state)
        S_IDLE: if (vs_rise && bus.i_en) state <= S_VBLANK;

        // Format is frozen per frame so a mid-frame mode change cannot mix encodings.
        S_VBLANK: if (vs_fall) begin
          state     <= S_ACTIVE;
          mode_q    <= bus.i_mode;
          x         <= '0;
          y         <= '0;
          addr      <= '0;
          full      <= 1'b0;
          bus.o_err <= '0;
        end

        S_ACTIVE: begin
          if (pix_done) begin
            x <= x + 16'd1;
            if (keep) begin
              if (full) bus.o_err[ERR_OVF] <= 1'b1;
              else begin
                bus.o_pix_wr   <= 1'b1;
                bus.o_pix_addr <= addr;
                bus.o_pix_data <= PIX_W'(pix_pack(mode_q, b0, bus.i_byte));
                // Saturate at the last slot; further writes flag overflow instead of wrapping.
                if (addr == ADDR_LAST) full <= 1'b1;
                else                   addr <= addr + 1'b1;
              end
            end
          end
          if (line_end) begin
            x <= '0;
            y <= y + 16'd1;
            if (x != H_END) bus.o_err[ERR_LEN] <= 1'b1;
          end
          if (vs_rise) begin
            bus.o_frame_done <= 1'b1;
            bus.o_frame_cnt  <= bus.o_frame_cnt + FCNT_W'(1);
            if (y_end != V_END) bus.o_err[ERR_CNT] <= 1'b1;
            state <= bus.i_en ? S_VBLANK : S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_pix_capture.sv
// Random-frame bench for cam_pix_capture: two instances (no decimation and 2:1)
// checked against a pixel/line/frame level reference model.
`timescale 1ns/1ps
module tb_cam_pix_capture;
  import cam_pkg::*;

  localparam int H = 16, V = 6, AW = 8, PW = 12, FW = 8;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int err; int cnt; } fr_t;

  logic       pclk = 1'b0, rst_n;
  logic       en, vs, hr;
  logic [7:0] bt;
  logic [1:0] md;
  int         cyc = 0;
  int         n_chk = 0, n_err = 0;
  int         n_wr0 = 0, n_wr1 = 0;
  int         last_d0 = 0, last_d1 = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  cam_pix_capture_if #(.ADDR_W(AW), .PIX_W(PW), .FCNT_W(FW)) bus0 ();
  cam_pix_capture_if #(.ADDR_W(AW), .PIX_W(PW), .FCNT_W(FW)) bus1 ();

  assign bus0.i_en = en;  assign bus0.i_mode = mode_e'(md);
  assign bus0.i_vsync = vs; assign bus0.i_href = hr; assign bus0.i_byte = bt;
  assign bus1.i_en = en;  assign bus1.i_mode = mode_e'(md);
  assign bus1.i_vsync = vs; assign bus1.i_href = hr; assign bus1.i_byte = bt;

  cam_pix_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .DECIM_LOG2(0),
                    .ADDR_W(AW), .FCNT_W(FW))
    dut0 (.i_pclk(pclk), .i_rstn_pclk(rst_n), .bus(bus0));
  cam_pix_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .DECIM_LOG2(1),
                    .ADDR_W(AW), .FCNT_W(FW))
    dut1 (.i_pclk(pclk), .i_rstn_pclk(rst_n), .bus(bus1));

  // ---------------- reference model ----------------
  wr_t wq0[$], wq1[$];
  fr_t fq0[$], fq1[$];
  bit  armed = 0, in_frm = 0, len_err = 0;
  bit  ovf[2];
  int  wcnt[2];
  int  my = 0, mmode = 0, fcnt = 0;
  bit  use_fix = 0;
  logic [7:0] fb0 = 8'h00, fb1 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pix(input int m, input int b0, input int b1);
    int r5, g6, b5;
    case (m)
      0: return (b0 % 16) * 256 + b1;
      1: begin
        r5 = b0 / 8;
        g6 = (b0 % 8) * 8 + b1 / 32;
        b5 = b1 % 32;
        return (r5 / 2) * 256 + (g6 / 4) * 16 + b5 / 2;
      end
      2: return (b0 / 16) * 'h111;
      default: return -1;
    endcase
  endfunction

  task automatic mdl_pix(input int x, input int b0, input int b1);
    wr_t w;
    if (!in_frm || mmode == 3) return;
    for (int k = 0; k < 2; k++) begin
      if ((x % (1 << k)) == 0 && (my % (1 << k)) == 0) begin
        if (wcnt[k] >= (H >> k) * (V >> k)) ovf[k] = 1;
        else begin
          w.addr = wcnt[k]; w.data = ref_pix(mmode, b0, b1); w.cyc = cyc + 1;
          if (k == 0) wq0.push_back(w); else wq1.push_back(w);
          wcnt[k]++;
        end
      end
    end
  endtask

  task automatic mdl_line(input int npix);
    if (!in_frm) return;
    if (npix != H) len_err = 1;
    my++;
  endtask

  task automatic mdl_rise();
    fr_t f;
    if (in_frm) begin
      fcnt = (fcnt + 1) % 256;
      for (int k = 0; k < 2; k++) begin
        f.err = (ovf[k] ? 4 : 0) + (len_err ? 2 : 0) + ((my != V) ? 1 : 0);
        f.cnt = fcnt;
        if (k == 0) fq0.push_back(f); else fq1.push_back(f);
      end
      in_frm = 0;
      armed  = (en === 1'b1);
    end else armed = armed | (en === 1'b1);
  endtask

  task automatic mdl_fall();
    if (!armed) return;
    armed = 0; in_frm = 1; my = 0; len_err = 0; mmode = int'(md);
    for (int k = 0; k < 2; k++) begin wcnt[k] = 0; ovf[k] = 0; end
  endtask

  task automatic mdl_rst();
    wq0.delete(); wq1.delete(); fq0.delete(); fq1.delete();
    armed = 0; in_frm = 0; fcnt = 0;
  endtask

  // ---------------- stimulus ----------------
  task automatic drv(input logic v, input logic h, input logic [7:0] b);
    @(negedge pclk);
    vs = v; hr = h; bt = b;
  endtask

  task automatic send_line(input int npix, input bit odd, input bit keep);
    logic [7:0] b0, b1;
    for (int p = 0; p < npix; p++) begin
      b0 = use_fix ? fb0 : 8'($urandom);
      b1 = use_fix ? fb1 : 8'($urandom);
      drv(1'b0, 1'b1, b0);
      drv(1'b0, 1'b1, b1);
      mdl_pix(p, int'(b0), int'(b1));
    end
    if (odd) drv(1'b0, 1'b1, 8'($urandom));
    if (!keep) begin
      mdl_line(npix);
      repeat ($urandom_range(4, 1)) drv(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  // mid >= 0: a line of that many pixels is still open when vsync rises.
  task automatic vs_up(input int mid);
    drv(1'b1, mid >= 0, 8'($urandom));
    if (mid >= 0) mdl_line(mid);
    mdl_rise();
    repeat ($urandom_range(5, 2)) drv(1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic vs_dn();
    drv(1'b0, 1'b0, 8'($urandom));
    mdl_fall();
    repeat ($urandom_range(3, 1)) drv(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic vs_pulse(input int mid);
    vs_up(mid);
    vs_dn();
  endtask

  task automatic full_frame();
    for (int l = 0; l < V; l++) send_line(H, 0, 0);
  endtask

  task automatic rand_frame();
    int nl, np;
    nl = ($urandom_range(3, 0) == 0) ? V - 1 + $urandom_range(2, 0) : V;
    for (int l = 0; l < nl; l++) begin
      np = ($urandom_range(5, 0) == 0) ? H - 2 + $urandom_range(4, 0) : H;
      send_line(np, $urandom_range(3, 0) == 0, 0);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic done, input logic [31:0] cnt, input logic [31:0] err);
    wr_t w;
    fr_t f;
    int  left;
    if (wr === 1'b1) begin
      if (k == 0) begin n_wr0++; last_d0 = int'(d); end
      else        begin n_wr1++; last_d1 = int'(d); end
      if ((k == 0 && wq0.size() == 0) || (k == 1 && wq1.size() == 0))
        chk($sformatf("d%0d_wr_extra", k), 32'(1), 32'(0));
      else begin
        if (k == 0) w = wq0.pop_front(); else w = wq1.pop_front();
        chk($sformatf("d%0d_wr_addr", k), a, w.addr);
        chk($sformatf("d%0d_wr_data", k), d, w.data);
        chk($sformatf("d%0d_wr_cycle", k), cyc, w.cyc);
      end
    end
    if (done === 1'b1) begin
      if ((k == 0 && fq0.size() == 0) || (k == 1 && fq1.size() == 0))
        chk($sformatf("d%0d_done_extra", k), 32'(1), 32'(0));
      else begin
        if (k == 0) f = fq0.pop_front(); else f = fq1.pop_front();
        left = (k == 0) ? wq0.size() : wq1.size();
        chk($sformatf("d%0d_frm_err", k), err, f.err);
        chk($sformatf("d%0d_frm_cnt", k), cnt, f.cnt);
        chk($sformatf("d%0d_wr_missing", k), left, 0);
      end
    end
  endtask

  always @(negedge pclk) begin
    if (rst_n === 1'b1) begin
      mon(0, bus0.o_pix_wr, 32'(bus0.o_pix_addr), 32'(bus0.o_pix_data),
          bus0.o_frame_done, 32'(bus0.o_frame_cnt), 32'(bus0.o_err));
      mon(1, bus1.o_pix_wr, 32'(bus1.o_pix_addr), 32'(bus1.o_pix_data),
          bus1.o_frame_done, 32'(bus1.o_frame_cnt), 32'(bus1.o_err));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_d0_wr"},   32'(bus0.o_pix_wr),     0);
    chk({tag, "_d0_addr"}, 32'(bus0.o_pix_addr),   0);
    chk({tag, "_d0_data"}, 32'(bus0.o_pix_data),   0);
    chk({tag, "_d0_cnt"},  32'(bus0.o_frame_cnt),  0);
    chk({tag, "_d0_err"},  32'(bus0.o_err),        0);
    chk({tag, "_d0_done"}, 32'(bus0.o_frame_done), 0);
    chk({tag, "_d1_addr"}, 32'(bus1.o_pix_addr),   0);
    chk({tag, "_d1_cnt"},  32'(bus1.o_frame_cnt),  0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nw;
    logic [7:0] b0, b1;
    rst_n = 1'b0; en = 1'b1; md = 2'd0; vs = 1'b0; hr = 1'b0; bt = 8'h00;
    repeat (3) @(negedge pclk);
    chk_zero("reset");
    rst_n = 1'b1;

    md = 2'd0; vs_pulse(-1); full_frame();
    md = 2'd1; use_fix = 1; fb0 = 8'hF8; fb1 = 8'h1F; vs_pulse(-1); full_frame();
    chk("rgb565_d0", last_d0, 'hF0F);
    chk("rgb565_d1", last_d1, 'hF0F);
    md = 2'd2; fb0 = 8'hA5; fb1 = 8'h3C; vs_pulse(-1); full_frame();
    chk("gray_d0", last_d0, 'hAAA);
    use_fix = 0;
    md = 2'd3; vs_pulse(-1); nw = n_wr0 + n_wr1; full_frame();
    chk("rsvd_nowr", n_wr0 + n_wr1 - nw, 0);

    // Row 0 one pixel long: length error plus one write past the end.
    md = 2'd0; vs_pulse(-1);
    send_line(H + 1, 0, 0);
    for (int l = 1; l < V; l++) send_line(H, 0, 0);
    vs_up(-1);
    chk("ovf_sticky_d0", 32'(bus0.o_err), 6);
    chk("ovf_sticky_d1", 32'(bus1.o_err), 6);
    vs_dn();
    chk("err_clr_d0", 32'(bus0.o_err), 0);
    chk("err_clr_d1", 32'(bus1.o_err), 0);

    // Last line cut short by vsync while HREF is still high.
    for (int l = 1; l < V; l++) send_line(H, 0, 0);
    send_line(5, 0, 1);
    vs_pulse(5);

    // Enable dropped mid-frame: this frame completes, the next one is ignored.
    send_line(H, 0, 0); send_line(H, 0, 0);
    en = 1'b0;
    for (int l = 2; l < V; l++) send_line(H, 0, 0);
    vs_pulse(-1);
    nw = n_wr0 + n_wr1;
    full_frame();
    chk("idle_nowr", n_wr0 + n_wr1 - nw, 0);
    en = 1'b1;
    vs_pulse(-1);

    // Async reset in the middle of a line.
    send_line(H, 0, 0); send_line(H, 0, 0);
    for (int p = 0; p < 5; p++) begin
      b0 = 8'($urandom); b1 = 8'($urandom);
      drv(1'b0, 1'b1, b0); drv(1'b0, 1'b1, b1);
      mdl_pix(p, int'(b0), int'(b1));
    end
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    mdl_rst();
    repeat (4) drv(1'b0, 1'b1, 8'($urandom));
    rst_n = 1'b1;
    repeat (8) drv(1'b0, 1'b1, 8'($urandom));
    drv(1'b0, 1'b0, 8'h00);
    nw = n_wr0 + n_wr1;
    send_line(H, 0, 0); send_line(H, 0, 0);
    chk("arst_nowr", n_wr0 + n_wr1 - nw, 0);
    vs_pulse(-1);
    full_frame();

    for (int i = 0; i < 15; i++) begin
      md = ($urandom_range(5, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      vs_pulse(-1);
      rand_frame();
    end
    vs_up(-1);
    repeat (4) drv(1'b1, 1'b0, 8'h00);

    chk("end_wq0", wq0.size(), 0);
    chk("end_wq1", wq1.size(), 0);
    chk("end_fq0", fq0.size(), 0);
    chk("end_fq1", fq1.size(), 0);
    chk("end_cnt_d0", 32'(bus0.o_frame_cnt), fcnt);
    chk("end_cnt_d1", 32'(bus1.o_frame_cnt), fcnt);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
